conv_group_sched: RTL and testbench
===================================

CONV_GROUP_SCHED -- requirements
Module: conv_group_sched

Interface
REQ-001 SHALL have parameter LANES, default 8: channels per group; one pixel is LANES x 8 bits.
REQ-002 SHALL have parameter MAX_CI_GROUPS, default 128: window buffer depth in input-channel groups.
REQ-003 SHALL have parameter MAX_CO_GROUPS, default 128: largest accepted output-group count.
REQ-004 SHALL define W = 9 x LANES x 8 as the packed window width; tap (r,c) occupies bits [(r*3+c)*LANES*8 +: LANES*8].
REQ-005 SHALL have the following ports (clock and reset first); one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_ci_groups  in  10  C_in/LANES; latched on start.
- cfg_co_groups  in  10  C_out/LANES; latched on start.
- cfg_num_windows  in  32  windows in the layer; latched on start.
- cfg_kernel_1x1  in  1  1 = pass the centre tap only; latched on start.
- cfg_start  in  1  single-cycle layer start.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- in_window  in  W  live window from the window generator.
- in_valid  in  1  in_window is valid.
- in_ready  out  1  scheduler accepts in_window.
- out_window  out  W  window issued to the PE array.
- out_valid  out  1  out_window is valid.
- out_ready  in  1  downstream accepts the issue; also used as the weight read strobe.
- out_ci_idx  out  10  input group of the issue.
- out_co_idx  out  10  output group of the issue.
- out_first_ch  out  1  out_ci_idx == 0.
- out_last_ch  out  1  out_ci_idx == ci_groups-1.
- busy  out  1  state is STREAM or REPLAY.
- layer_done  out  1  one-cycle pulse when the layer completes.

Function
REQ-006 SHALL implement the states IDLE, STREAM, REPLAY and DONE.
REQ-007 SHALL define the output handshake as out_valid && out_ready; every advance in this document happens only on that handshake.
REQ-008 In IDLE, cfg_start with 1 <= ci <= MAX_CI_GROUPS, 1 <= co <= MAX_CO_GROUPS and num_windows >= 1 SHALL latch all cfg_* values, clear the counters and go to STREAM.
REQ-009 A start that fails any REQ-008 condition SHALL pulse cfg_err, leave the state at IDLE and latch nothing.
REQ-010 cfg_start asserted in any state other than IDLE SHALL be ignored.
REQ-011 In STREAM, the block SHALL drive combinationally (zero latency): in_ready = out_ready, out_valid = in_valid, out_window = in_window and out_co_idx = 0.
REQ-012 On each STREAM handshake, the block SHALL write in_window to buf[ci_cnt] and advance ci_cnt.
REQ-013 In STREAM, when the handshake carries the last input group:
- ci_cnt wraps to 0;
- if co > 1, co_cnt becomes 1 and the state goes to REPLAY;
- otherwise the window is complete (REQ-016).
REQ-014 In REPLAY, the block SHALL hold in_ready = 0 and out_valid = 1, and drive out_window = buf[ci_cnt] (asynchronous read) and out_co_idx = co_cnt.
REQ-015 In REPLAY, each handshake SHALL advance ci_cnt; on the last input group, ci_cnt wraps to 0 and co_cnt advances. When co_cnt == co-1 on that last group, the window is complete and co_cnt returns to 0.
REQ-016 On window completion, the block SHALL increment win_cnt. If win_cnt reaches num_windows, it goes to DONE; otherwise it goes to (or stays in) STREAM.
REQ-017 DONE SHALL last exactly one cycle with layer_done = 1, then go to IDLE.
REQ-018 If out_ready is low, all counters, the buffer, the state and out_window SHALL hold; a replay that stalls mid-window resumes at the same (ci, co).
REQ-019 With cfg_kernel_1x1 = 1, out_window SHALL carry the centre tap (1,1) and zeros in the other 8 taps, in both STREAM and REPLAY.
REQ-020 In IDLE and DONE, in_ready and out_valid SHALL be 0.
REQ-021 out_first_ch and out_last_ch SHALL be combinational decodes of ci_cnt and are valid only while out_valid = 1.
REQ-022 The total number of output handshakes per layer SHALL equal num_windows x ci x co.
REQ-023 For ci = 1, the design SHALL treat every handshake as both the first and the last input group.

Reset
REQ-024 While rst = 0, the block SHALL asynchronously force:
- state = IDLE;
- ci_cnt, co_cnt and win_cnt = 0;
- latched configuration = 0;
- in_ready = out_valid = busy = layer_done = cfg_err = 0.
REQ-025 Buffer contents SHALL NOT be reset.
REQ-026 A reset asserted mid-layer SHALL abandon the layer; after release, no issue occurs until a new cfg_start.
REQ-027 Reset release SHALL be synchronised internally so that the first active edge is clean.

Verification
REQ-028 ci=2, co=1, num_windows=3, out_ready=1 -> 6 STREAM handshakes, no REPLAY; layer_done pulses once, one cycle after the 6th handshake.
REQ-029 ci=3, co=2, num_windows=1, windows tagged A0..A2 -> issues A0,A1,A2 with co=0, then A0,A1,A2 with co=1; in_ready = 0 during the replay.
REQ-030 Same configuration as REQ-029 with out_ready low for 4 cycles at replay (ci=1, co=1) -> A1 held stable throughout, then the sequence continues unchanged.
REQ-031 cfg_kernel_1x1=1 with in_window all 0xFF -> only tap (1,1) is 0xFF…; the other taps are 0 on all issues.
REQ-032 cfg_ci_groups=0, or cfg_co_groups=MAX_CO_GROUPS+1 -> cfg_err pulse, state stays IDLE, no out_valid.
REQ-033 rst=0 asserted in REPLAY at (ci=1, co=1) -> outputs are 0 immediately; after release, no out_valid until cfg_start.

Source files
------------

// File: rtl/conv_group_sched.sv
// Output-group scheduler: streams each live window to the PE array once per input group,
// then replays it from a local buffer for every further output group.
module conv_group_sched #(
  parameter  int LANES         = 8,
  parameter  int MAX_CI_GROUPS = 128,
  parameter  int MAX_CO_GROUPS = 128,
  localparam int W             = 9 * LANES * 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    cfg_ci_groups,
  input  logic [9:0]    cfg_co_groups,
  input  logic [31:0]   cfg_num_windows,
  input  logic          cfg_kernel_1x1,
  input  logic          cfg_start,
  output logic          cfg_err,
  input  logic [W-1:0]  in_window,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_window,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [9:0]    out_ci_idx,
  output logic [9:0]    out_co_idx,
  output logic          out_first_ch,
  output logic          out_last_ch,
  output logic          busy,
  output logic          layer_done
);

  localparam int TAP_W = LANES * 8;
  localparam int AW    = (MAX_CI_GROUPS > 1) ? $clog2(MAX_CI_GROUPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_REPLAY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t         state_r;
  logic [1:0]     rst_sync_r;
  logic           rst_n_s;
  logic [9:0]     ci_r;
  logic [9:0]     co_r;
  logic [31:0]    nw_r;
  logic           k1_r;
  logic [9:0]     ci_cnt_r;
  logic [9:0]     co_cnt_r;
  logic [31:0]    win_cnt_r;
  logic           cfg_err_r;
  logic           layer_done_r;
  logic [W-1:0]   win_buf_r [MAX_CI_GROUPS];
  logic [AW-1:0]  ci_addr_s;
  logic [W-1:0]   raw_window_s;
  logic           cfg_ok_s;
  logic           ci_last_s;
  logic           win_last_s;
  logic           stream_hs_s;

  // Keep only the centre tap (1,1) of a 3x3 window.
  function automatic logic [W-1:0] centre_only(input logic [W-1:0] w);
    logic [W-1:0] mask;
    mask = {{(4 * TAP_W){1'b0}}, {TAP_W{1'b1}}, {(4 * TAP_W){1'b0}}};
    return w & mask;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  assign ci_addr_s   = ci_cnt_r[AW-1:0];
  assign ci_last_s   = (ci_cnt_r == (ci_r - 10'd1));
  assign win_last_s  = ((win_cnt_r + 32'd1) == nw_r);
  assign stream_hs_s = (state_r == ST_STREAM) && in_valid && out_ready;
  assign cfg_ok_s    = (cfg_ci_groups >= 10'd1) && (32'(cfg_ci_groups) <= 32'(MAX_CI_GROUPS)) &&
                       (cfg_co_groups >= 10'd1) && (32'(cfg_co_groups) <= 32'(MAX_CO_GROUPS)) &&
                       (cfg_num_windows >= 32'd1);

  // Scheduler state, counters, latched configuration and pulse outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= ST_IDLE;
      ci_r         <= 10'd0;
      co_r         <= 10'd0;
      nw_r         <= 32'd0;
      k1_r         <= 1'b0;
      ci_cnt_r     <= 10'd0;
      co_cnt_r     <= 10'd0;
      win_cnt_r    <= 32'd0;
      cfg_err_r    <= 1'b0;
      layer_done_r <= 1'b0;
    end else begin
      cfg_err_r    <= 1'b0;
      layer_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_ok_s) begin
              ci_r      <= cfg_ci_groups;
              co_r      <= cfg_co_groups;
              nw_r      <= cfg_num_windows;
              k1_r      <= cfg_kernel_1x1;
              ci_cnt_r  <= 10'd0;
              co_cnt_r  <= 10'd0;
              win_cnt_r <= 32'd0;
              state_r   <= ST_STREAM;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (stream_hs_s) begin
            if (ci_last_s) begin
              ci_cnt_r <= 10'd0;
              if (co_r > 10'd1) begin
                co_cnt_r <= 10'd1;
                state_r  <= ST_REPLAY;
              end else begin
                win_cnt_r <= win_cnt_r + 32'd1;
                if (win_last_s) begin
                  state_r      <= ST_DONE;
                  layer_done_r <= 1'b1;
                end
              end
            end else begin
              ci_cnt_r <= ci_cnt_r + 10'd1;
            end
          end
        end
        ST_REPLAY: begin
          if (out_ready) begin
            if (ci_last_s) begin
              ci_cnt_r <= 10'd0;
              if (co_cnt_r == (co_r - 10'd1)) begin
                // Final output group of this window: account for it and pick the next window.
                co_cnt_r  <= 10'd0;
                win_cnt_r <= win_cnt_r + 32'd1;
                if (win_last_s) begin
                  state_r      <= ST_DONE;
                  layer_done_r <= 1'b1;
                end else begin
                  state_r <= ST_STREAM;
                end
              end else begin
                co_cnt_r <= co_cnt_r + 10'd1;
              end
            end else begin
              ci_cnt_r <= ci_cnt_r + 10'd1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Window buffer captures each streamed input group for later replay; never reset.
  always_ff @(posedge clk) begin
    if (stream_hs_s) begin
      win_buf_r[ci_addr_s] <= in_window;
    end
  end

  // Zero-latency issue path: live window in STREAM, buffered window in REPLAY.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    raw_window_s = {W{1'b0}};
    out_co_idx   = 10'd0;
    case (state_r)
      ST_STREAM: begin
        in_ready     = out_ready;
        out_valid    = in_valid;
        raw_window_s = in_window;
      end
      ST_REPLAY: begin
        out_valid    = 1'b1;
        raw_window_s = win_buf_r[ci_addr_s];
        out_co_idx   = co_cnt_r;
      end
      default: begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        raw_window_s = {W{1'b0}};
        out_co_idx   = 10'd0;
      end
    endcase
  end

  assign out_window   = k1_r ? centre_only(raw_window_s) : raw_window_s;
  assign out_ci_idx   = ci_cnt_r;
  assign out_first_ch = (ci_cnt_r == 10'd0);
  assign out_last_ch  = ci_last_s;
  assign busy         = (state_r == ST_STREAM) || (state_r == ST_REPLAY);
  assign cfg_err      = cfg_err_r;
  assign layer_done   = layer_done_r;

endmodule

// File: tb/tb_conv_group_sched.sv
// Directed self-checking bench for conv_group_sched: streaming, replay, stall,
// 1x1 masking, rejected starts and mid-layer reset.
module tb_conv_group_sched;

  localparam int LANES = 8;
  localparam int W     = 9 * LANES * 8;

  logic          clk;
  logic          rst;
  logic [9:0]    cfg_ci_groups;
  logic [9:0]    cfg_co_groups;
  logic [31:0]   cfg_num_windows;
  logic          cfg_kernel_1x1;
  logic          cfg_start;
  logic          cfg_err;
  logic [W-1:0]  in_window;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_window;
  logic          out_valid;
  logic          out_ready;
  logic [9:0]    out_ci_idx;
  logic [9:0]    out_co_idx;
  logic          out_first_ch;
  logic          out_last_ch;
  logic          busy;
  logic          layer_done;

  int n_cmp;
  int n_bad;

  conv_group_sched #(.LANES(LANES), .MAX_CI_GROUPS(128), .MAX_CO_GROUPS(128)) dut (
    .clk(clk), .rst(rst),
    .cfg_ci_groups(cfg_ci_groups), .cfg_co_groups(cfg_co_groups),
    .cfg_num_windows(cfg_num_windows), .cfg_kernel_1x1(cfg_kernel_1x1),
    .cfg_start(cfg_start), .cfg_err(cfg_err),
    .in_window(in_window), .in_valid(in_valid), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready),
    .out_ci_idx(out_ci_idx), .out_co_idx(out_co_idx),
    .out_first_ch(out_first_ch), .out_last_ch(out_last_ch),
    .busy(busy), .layer_done(layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkwin(input logic [7:0] t);
    return {(W / 8){t}};
  endfunction

  function automatic logic [W-1:0] centre_mask();
    logic [W-1:0] m;
    m = {W{1'b0}};
    for (int b = 0; b < W; b++) begin
      if ((b / (LANES * 8)) == 4) m[b] = 1'b1;
    end
    return m;
  endfunction

  task automatic start_layer(input logic [9:0] ci, input logic [9:0] co, input logic [31:0] nw, input logic k1);
    @(negedge clk);
    cfg_ci_groups   = ci;
    cfg_co_groups   = co;
    cfg_num_windows = nw;
    cfg_kernel_1x1  = k1;
    cfg_start       = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Check one issue: valid, window and indices.
  task automatic check_issue(input string tag, input logic [W-1:0] w, input logic [9:0] ci, input logic [9:0] co,
                             input logic first, input logic last);
    check_eq({tag, ".valid"}, W'(out_valid), W'(1'b1));
    check_eq({tag, ".win"},   out_window, w);
    check_eq({tag, ".ci"},    W'(out_ci_idx), W'(ci));
    check_eq({tag, ".co"},    W'(out_co_idx), W'(co));
    check_eq({tag, ".first"}, W'(out_first_ch), W'(first));
    check_eq({tag, ".last"},  W'(out_last_ch), W'(last));
  endtask

  initial begin
    logic [W-1:0] a_win [3];
    logic [W-1:0] ff_win;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    cfg_ci_groups = 10'd0; cfg_co_groups = 10'd0; cfg_num_windows = 32'd0;
    cfg_kernel_1x1 = 1'b0; cfg_start = 1'b0;
    in_window = {W{1'b0}}; in_valid = 1'b1; out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst.out_valid", W'(out_valid), W'(1'b0));
    check_eq("rst.in_ready", W'(in_ready), W'(1'b0));
    check_eq("rst.busy", W'(busy), W'(1'b0));
    check_eq("rst.layer_done", W'(layer_done), W'(1'b0));
    check_eq("rst.cfg_err", W'(cfg_err), W'(1'b0));
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("idle.out_valid", W'(out_valid), W'(1'b0));
    check_eq("idle.in_ready", W'(in_ready), W'(1'b0));

    // ci=2, co=1, three windows: six streamed issues, then one-cycle layer_done
    start_layer(10'd2, 10'd1, 32'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_window = mkwin(8'h10 + 8'(i));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cfg_start = (i == 2);
      cfg_ci_groups = (i == 2) ? 10'd0 : 10'd2;
      #1;
      check_issue($sformatf("s1.%0d", i), mkwin(8'h10 + 8'(i)), 10'(i % 2), 10'd0, (i % 2) == 0, (i % 2) == 1);
      check_eq("s1.in_ready", W'(in_ready), W'(1'b1));
      check_eq("s1.busy", W'(busy), W'(1'b1));
      check_eq("s1.cfg_err", W'(cfg_err), W'(1'b0));
      check_eq("s1.layer_done", W'(layer_done), W'(1'b0));
      @(negedge clk);
    end
    cfg_start = 1'b0;
    #1;
    check_eq("s1.done", W'(layer_done), W'(1'b1));
    check_eq("s1.done_valid", W'(out_valid), W'(1'b0));
    check_eq("s1.done_in_ready", W'(in_ready), W'(1'b0));
    check_eq("s1.done_busy", W'(busy), W'(1'b0));
    @(negedge clk); #1;
    check_eq("s1.done_pulse", W'(layer_done), W'(1'b0));
    check_eq("s1.idle_valid", W'(out_valid), W'(1'b0));

    // ci=3, co=2, one window: stream A0..A2, replay with a 4-cycle stall on A1
    a_win[0] = mkwin(8'hA0); a_win[1] = mkwin(8'hA1); a_win[2] = mkwin(8'hA2);
    start_layer(10'd3, 10'd2, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_window = a_win[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check_issue($sformatf("s2.str%0d", i), a_win[i], 10'(i), 10'd0, i == 0, i == 2);
      check_eq("s2.str_in_ready", W'(in_ready), W'(1'b1));
      @(negedge clk);
    end
    in_window = mkwin(8'h5A);
    #1;
    check_issue("s2.rep0", a_win[0], 10'd0, 10'd1, 1'b1, 1'b0);
    check_eq("s2.rep_in_ready", W'(in_ready), W'(1'b0));
    check_eq("s2.rep_busy", W'(busy), W'(1'b1));
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_issue($sformatf("s2.stall%0d", k), a_win[1], 10'd1, 10'd1, 1'b0, 1'b0);
      check_eq("s2.stall_in_ready", W'(in_ready), W'(1'b0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_issue("s2.rep1", a_win[1], 10'd1, 10'd1, 1'b0, 1'b0);
    @(negedge clk); #1;
    check_issue("s2.rep2", a_win[2], 10'd2, 10'd1, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_eq("s2.done", W'(layer_done), W'(1'b1));
    check_eq("s2.done_valid", W'(out_valid), W'(1'b0));

    // 1x1 kernel, ci=1, co=2: only the centre tap survives, streamed and replayed
    ff_win = mkwin(8'hFF);
    start_layer(10'd1, 10'd2, 32'd1, 1'b1);
    in_window = ff_win; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_issue("s3.str", ff_win & centre_mask(), 10'd0, 10'd0, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_issue("s3.rep", ff_win & centre_mask(), 10'd0, 10'd1, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_eq("s3.done", W'(layer_done), W'(1'b1));

    // Rejected starts: ci=0, then co=MAX+1
    start_layer(10'd0, 10'd1, 32'd1, 1'b0);
    in_valid = 1'b1;
    #1;
    check_eq("e1.cfg_err", W'(cfg_err), W'(1'b1));
    check_eq("e1.busy", W'(busy), W'(1'b0));
    check_eq("e1.out_valid", W'(out_valid), W'(1'b0));
    @(negedge clk); #1;
    check_eq("e1.err_pulse", W'(cfg_err), W'(1'b0));
    check_eq("e1.out_valid2", W'(out_valid), W'(1'b0));
    start_layer(10'd1, 10'd129, 32'd1, 1'b0);
    #1;
    check_eq("e2.cfg_err", W'(cfg_err), W'(1'b1));
    check_eq("e2.out_valid", W'(out_valid), W'(1'b0));
    @(negedge clk); #1;
    check_eq("e2.out_valid2", W'(out_valid), W'(1'b0));
    check_eq("e2.busy", W'(busy), W'(1'b0));

    // Reset in REPLAY at (ci=1, co=1), then nothing issues until a new start
    start_layer(10'd3, 10'd2, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_window = a_win[i % 3]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    check_issue("r.pre", a_win[1], 10'd1, 10'd1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("r.out_valid", W'(out_valid), W'(1'b0));
    check_eq("r.in_ready", W'(in_ready), W'(1'b0));
    check_eq("r.busy", W'(busy), W'(1'b0));
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("r.post_valid", W'(out_valid), W'(1'b0));
      @(negedge clk);
    end
    start_layer(10'd1, 10'd1, 32'd1, 1'b0);
    in_window = mkwin(8'h77);
    #1;
    check_issue("r.restart", mkwin(8'h77), 10'd0, 10'd0, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_eq("r.done", W'(layer_done), W'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
